// File: rtl/bmem_arbiter.sv
// Arbiter that shares the banked burst-memory port between the I-cache and D-cache miss paths.
// Reads are tracked in a small tag table so that out-of-order return beats reach their owner.
module bmem_arbiter #(
    parameter int unsigned BURST_LEN   = 4,
    parameter int unsigned OUTSTANDING = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] i_addr,
    input  logic        i_read,
    output logic        i_ready,
    output logic [63:0] i_rdata,
    output logic        i_rvalid,
    input  logic [31:0] d_addr,
    input  logic        d_read,
    input  logic        d_write,
    input  logic [63:0] d_wdata,
    output logic        d_ready,
    output logic [63:0] d_rdata,
    output logic        d_rvalid,
    output logic [31:0] bmem_addr,
    output logic        bmem_read,
    output logic        bmem_write,
    output logic [63:0] bmem_wdata,
    input  logic        bmem_ready,
    input  logic [31:0] bmem_raddr,
    input  logic [63:0] bmem_rdata,
    input  logic        bmem_rvalid
);

    localparam int unsigned IW = (OUTSTANDING > 1) ? $clog2(OUTSTANDING) : 1;
    localparam int unsigned CW = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1;

    typedef enum logic {IDLE, WBURST} state_t;

    state_t                 state;
    logic                   rr;          // 0: I has priority, 1: D has priority
    logic [OUTSTANDING-1:0] tv;
    logic [OUTSTANDING-1:0] town;        // 1: entry owned by D
    logic [31:0]            taddr [OUTSTANDING];
    logic [CW-1:0]          tcnt  [OUTSTANDING];
    logic [CW-1:0]          wcnt;
    logic [31:0]            waddr;
    logic                   err_flag;

    logic          has_free, i_conf, d_conf, ret_hit;
    logic [IW-1:0] free_idx, ret_idx;
    logic          i_elig, d_rd_elig, d_elig, grant_i, grant_d;
    logic          acc_i, acc_d, wr_beat, rd_alloc, ret_ok;

    // Table lookups: lowest free entry, address hazards and return-tag match
    always_comb begin
        has_free = 1'b0;
        free_idx = '0;
        i_conf   = 1'b0;
        d_conf   = 1'b0;
        ret_hit  = 1'b0;
        ret_idx  = '0;
        for (int k = OUTSTANDING - 1; k >= 0; k--) begin
            if (!tv[k]) begin
                has_free = 1'b1;
                free_idx = IW'(k);
            end
            if (tv[k] && taddr[k] == i_addr) i_conf = 1'b1;
            if (tv[k] && taddr[k] == d_addr) d_conf = 1'b1;
            if (tv[k] && taddr[k] == bmem_raddr) begin
                ret_hit = 1'b1;
                ret_idx = IW'(k);
            end
        end
    end

    // Round-robin grant and same-cycle drive of the memory port
    always_comb begin
        i_elig    = i_read & has_free & ~i_conf;
        d_rd_elig = d_read & has_free & ~d_conf;
        d_elig    = d_write | d_rd_elig;
        grant_i   = (state == IDLE) & i_elig & (~d_elig | ~rr);
        grant_d   = (state == IDLE) & d_elig & ~grant_i;
        acc_i     = grant_i & bmem_ready & ~rst;
        acc_d     = grant_d & bmem_ready & ~rst;
        wr_beat   = (state == WBURST) & d_write & bmem_ready & ~rst;
        rd_alloc  = acc_i | (acc_d & ~d_write);
        ret_ok    = bmem_rvalid & ret_hit & ~rst;

        i_ready    = acc_i;
        d_ready    = acc_d | wr_beat;
        bmem_read  = rd_alloc;
        bmem_write = (acc_d & d_write) | wr_beat;
        bmem_addr  = '0;
        if (acc_i)        bmem_addr = i_addr;
        else if (acc_d)   bmem_addr = d_addr;
        else if (wr_beat) bmem_addr = waddr;
        bmem_wdata = bmem_write ? d_wdata : 64'h0;

        i_rvalid = ret_ok & ~town[ret_idx];
        d_rvalid = ret_ok &  town[ret_idx];
        i_rdata  = i_rvalid ? bmem_rdata : 64'h0;
        d_rdata  = d_rvalid ? bmem_rdata : 64'h0;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            rr       <= 1'b0;
            tv       <= '0;
            town     <= '0;
            wcnt     <= '0;
            waddr    <= '0;
            err_flag <= 1'b0;
            for (int k = 0; k < OUTSTANDING; k++) begin
                taddr[k] <= '0;
                tcnt[k]  <= '0;
            end
        end else begin
            assert (!(bmem_rvalid && !ret_hit)) else $error("bmem_arbiter: unmatched return tag %h", bmem_raddr);
            err_flag <= err_flag | (bmem_rvalid & ~ret_hit);

            // Return beat bookkeeping; a freed entry is only seen as free next cycle
            if (ret_ok) begin
                if (tcnt[ret_idx] == CW'(BURST_LEN - 1)) begin
                    tv[ret_idx]   <= 1'b0;
                    tcnt[ret_idx] <= '0;
                end else begin
                    tcnt[ret_idx] <= tcnt[ret_idx] + CW'(1);
                end
            end

            if (rd_alloc) begin
                tv[free_idx]    <= 1'b1;
                town[free_idx]  <= acc_d;
                taddr[free_idx] <= acc_i ? i_addr : d_addr;
                tcnt[free_idx]  <= '0;
            end

            case (state)
                IDLE: begin
                    if (acc_i || acc_d) rr <= acc_i;
                    if (acc_d && d_write) begin
                        state <= WBURST;
                        wcnt  <= CW'(1);
                        waddr <= d_addr;
                    end
                end
                WBURST: begin
                    if (wr_beat) begin
                        if (wcnt == CW'(BURST_LEN - 1)) begin
                            state <= IDLE;
                            wcnt  <= '0;
                            rr    <= 1'b0;
                        end else begin
                            wcnt <= wcnt + CW'(1);
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_bmem_arbiter.sv
// Directed bench for bmem_arbiter: grants, write bursts, table full, hazards and reset.
module tb_bmem_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] i_addr, d_addr, bmem_addr, bmem_raddr;
    logic        i_read, i_ready, i_rvalid;
    logic        d_read, d_write, d_ready, d_rvalid;
    logic [63:0] i_rdata, d_rdata, d_wdata, bmem_wdata, bmem_rdata;
    logic        bmem_read, bmem_write, bmem_ready, bmem_rvalid;

    int passed = 0;
    int total  = 0;

    bmem_arbiter #(.BURST_LEN(4), .OUTSTANDING(4)) dut (
        .clk(clk), .rst(rst),
        .i_addr(i_addr), .i_read(i_read), .i_ready(i_ready), .i_rdata(i_rdata), .i_rvalid(i_rvalid),
        .d_addr(d_addr), .d_read(d_read), .d_write(d_write), .d_wdata(d_wdata), .d_ready(d_ready),
        .d_rdata(d_rdata), .d_rvalid(d_rvalid),
        .bmem_addr(bmem_addr), .bmem_read(bmem_read), .bmem_write(bmem_write), .bmem_wdata(bmem_wdata),
        .bmem_ready(bmem_ready), .bmem_raddr(bmem_raddr), .bmem_rdata(bmem_rdata), .bmem_rvalid(bmem_rvalid)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        i_read = 0; i_addr = '0; d_read = 0; d_write = 0; d_addr = '0; d_wdata = '0;
        bmem_ready = 1; bmem_rvalid = 0; bmem_raddr = '0; bmem_rdata = '0;
    endtask

    task automatic test_reset();
        rst = 1; clear_inputs();
        i_read = 1; i_addr = 32'h1000;
        tick(); tick();
        total++; if (i_ready !== 1'b0) $display("FAIL reset_i_ready: got %b want 0", i_ready); else passed++;
        total++; if (bmem_read !== 1'b0) $display("FAIL reset_bmem_read: got %b want 0", bmem_read); else passed++;
        total++; if (bmem_addr !== 32'h0) $display("FAIL reset_bmem_addr: got %h want 0", bmem_addr); else passed++;
        i_read = 0;
        rst = 0;
        tick();
    endtask

    task automatic test_single_read();
        i_read = 1; i_addr = 32'h1000;
        #1;
        total++; if (i_ready !== 1'b1) $display("FAIL single_ready: got %b want 1", i_ready); else passed++;
        total++; if (bmem_read !== 1'b1 || bmem_addr !== 32'h1000)
            $display("FAIL single_bmem: got read=%b addr=%h want read=1 addr=1000", bmem_read, bmem_addr); else passed++;
        tick(); i_read = 0;
        for (int k = 0; k < 4; k++) begin
            bmem_rvalid = 1; bmem_raddr = 32'h1000; bmem_rdata = 64'hAAAA_0000 + 64'(k);
            #1;
            total++; if (i_rvalid !== 1'b1 || i_rdata !== 64'hAAAA_0000 + 64'(k))
                $display("FAIL single_ret%0d: got v=%b d=%h want v=1 d=%h", k, i_rvalid, i_rdata, 64'hAAAA_0000 + 64'(k)); else passed++;
            total++; if (d_rvalid !== 1'b0) $display("FAIL single_ret%0d_d: got %b want 0", k, d_rvalid); else passed++;
            tick();
        end
        bmem_rvalid = 0;
        // a D read to the same line is accepted only if the entry was freed
        d_read = 1; d_addr = 32'h1000;
        #1;
        total++; if (d_ready !== 1'b1) $display("FAIL single_freed: got %b want 1", d_ready); else passed++;
        tick(); d_read = 0;
        for (int k = 0; k < 4; k++) begin
            bmem_rvalid = 1; bmem_raddr = 32'h1000; bmem_rdata = 64'hBB00 + 64'(k);
            #1;
            total++; if (d_rvalid !== 1'b1 || i_rvalid !== 1'b0 || d_rdata !== 64'hBB00 + 64'(k))
                $display("FAIL single_dret%0d: got dv=%b iv=%b d=%h want dv=1 iv=0 d=%h", k, d_rvalid, i_rvalid, d_rdata, 64'hBB00 + 64'(k)); else passed++;
            tick();
        end
        bmem_rvalid = 0;
    endtask

    task automatic test_round_robin();
        i_read = 1; i_addr = 32'h2000; d_read = 1; d_addr = 32'h3000;
        #1;
        total++; if (i_ready !== 1'b1 || d_ready !== 1'b0 || bmem_addr !== 32'h2000)
            $display("FAIL rr_c0: got ir=%b dr=%b addr=%h want ir=1 dr=0 addr=2000", i_ready, d_ready, bmem_addr); else passed++;
        tick(); i_read = 0;
        #1;
        total++; if (d_ready !== 1'b1 || bmem_read !== 1'b1 || bmem_addr !== 32'h3000)
            $display("FAIL rr_c1: got dr=%b rd=%b addr=%h want dr=1 rd=1 addr=3000", d_ready, bmem_read, bmem_addr); else passed++;
        tick(); d_read = 0;
        for (int k = 0; k < 8; k++) begin
            logic is_d;
            is_d = (k % 2 == 0);
            bmem_rvalid = 1;
            bmem_raddr  = is_d ? 32'h3000 : 32'h2000;
            bmem_rdata  = is_d ? 64'hD0 + 64'(k) : 64'h10 + 64'(k);
            #1;
            if (is_d) begin
                total++; if (d_rvalid !== 1'b1 || i_rvalid !== 1'b0 || d_rdata !== 64'hD0 + 64'(k))
                    $display("FAIL rr_ret%0d: got dv=%b iv=%b d=%h want dv=1 iv=0 d=%h", k, d_rvalid, i_rvalid, d_rdata, 64'hD0 + 64'(k)); else passed++;
            end else begin
                total++; if (i_rvalid !== 1'b1 || d_rvalid !== 1'b0 || i_rdata !== 64'h10 + 64'(k))
                    $display("FAIL rr_ret%0d: got iv=%b dv=%b d=%h want iv=1 dv=0 d=%h", k, i_rvalid, d_rvalid, i_rdata, 64'h10 + 64'(k)); else passed++;
            end
            tick();
        end
        bmem_rvalid = 0;
    endtask

    task automatic test_write_burst();
        logic [63:0] beats [4];
        beats[0] = 64'hA; beats[1] = 64'hB; beats[2] = 64'hC; beats[3] = 64'hD;
        d_write = 1; d_addr = 32'h4000; d_wdata = beats[0];
        #1;
        total++; if (d_ready !== 1'b1 || bmem_write !== 1'b1 || bmem_addr !== 32'h4000 || bmem_wdata !== 64'hA)
            $display("FAIL wb_b0: got dr=%b w=%b addr=%h wd=%h want 1 1 4000 a", d_ready, bmem_write, bmem_addr, bmem_wdata); else passed++;
        tick();
        i_read = 1; i_addr = 32'h7000; d_addr = 32'h4444;
        for (int k = 1; k < 4; k++) begin
            if (k == 2) begin
                bmem_ready = 0; d_wdata = beats[k];
                #1;
                total++; if (d_ready !== 1'b0 || bmem_write !== 1'b0 || i_ready !== 1'b0)
                    $display("FAIL wb_stall: got dr=%b w=%b ir=%b want 0 0 0", d_ready, bmem_write, i_ready); else passed++;
                tick();
                bmem_ready = 1;
            end
            d_wdata = beats[k];
            #1;
            total++; if (d_ready !== 1'b1 || bmem_write !== 1'b1 || bmem_addr !== 32'h4000 || bmem_wdata !== beats[k] || i_ready !== 1'b0)
                $display("FAIL wb_b%0d: got dr=%b w=%b addr=%h wd=%h ir=%b want 1 1 4000 %h 0", k, d_ready, bmem_write, bmem_addr, bmem_wdata, i_ready, beats[k]); else passed++;
            tick();
        end
        d_write = 0;
        #1;
        total++; if (i_ready !== 1'b1 || bmem_read !== 1'b1 || bmem_addr !== 32'h7000)
            $display("FAIL wb_i_after: got ir=%b rd=%b addr=%h want 1 1 7000", i_ready, bmem_read, bmem_addr); else passed++;
        tick(); i_read = 0;
        for (int k = 0; k < 4; k++) begin
            bmem_rvalid = 1; bmem_raddr = 32'h7000; bmem_rdata = 64'h70 + 64'(k);
            #1;
            total++; if (i_rvalid !== 1'b1) $display("FAIL wb_iret%0d: got %b want 1", k, i_rvalid); else passed++;
            tick();
        end
        bmem_rvalid = 0;
    endtask

    task automatic test_table_full();
        logic [31:0] fa [4];
        logic        fd [4];
        fa[0] = 32'hA000; fa[1] = 32'hB000; fa[2] = 32'hC000; fa[3] = 32'hD000;
        fd[0] = 0; fd[1] = 1; fd[2] = 0; fd[3] = 1;
        for (int k = 0; k < 4; k++) begin
            if (fd[k]) begin d_read = 1; d_addr = fa[k]; end
            else begin i_read = 1; i_addr = fa[k]; end
            #1;
            total++; if ((fd[k] ? d_ready : i_ready) !== 1'b1) $display("FAIL full_fill%0d: got 0 want 1", k); else passed++;
            tick(); i_read = 0; d_read = 0;
        end
        i_read = 1; i_addr = 32'h5000;
        for (int k = 0; k < 4; k++) begin
            bmem_rvalid = 1; bmem_raddr = 32'hA000; bmem_rdata = 64'h5A + 64'(k);
            #1;
            total++; if (i_ready !== 1'b0 || i_rvalid !== 1'b1)
                $display("FAIL full_stall%0d: got ir=%b iv=%b want ir=0 iv=1", k, i_ready, i_rvalid); else passed++;
            tick();
        end
        bmem_rvalid = 0;
        #1;
        total++; if (i_ready !== 1'b1 || bmem_addr !== 32'h5000)
            $display("FAIL full_accept: got ir=%b addr=%h want 1 5000", i_ready, bmem_addr); else passed++;
        tick(); i_read = 0;
        fa[0] = 32'h5000;
        for (int e = 0; e < 4; e++) begin
            for (int k = 0; k < 4; k++) begin
                bmem_rvalid = 1; bmem_raddr = fa[e]; bmem_rdata = 64'(e * 16 + k);
                #1;
                total++; if ((fd[e] ? d_rvalid : i_rvalid) !== 1'b1 || (fd[e] ? i_rvalid : d_rvalid) !== 1'b0)
                    $display("FAIL full_drain%0d_%0d: got iv=%b dv=%b want owner %0d", e, k, i_rvalid, d_rvalid, fd[e]); else passed++;
                tick();
            end
        end
        bmem_rvalid = 0;
    endtask

    task automatic test_hazard();
        i_read = 1; i_addr = 32'h6000;
        #1;
        total++; if (i_ready !== 1'b1) $display("FAIL hz_i_accept: got %b want 1", i_ready); else passed++;
        tick();
        d_read = 1; d_addr = 32'h6000; i_addr = 32'h6100;
        #1;
        total++; if (d_ready !== 1'b0 || i_ready !== 1'b1 || bmem_addr !== 32'h6100)
            $display("FAIL hz_other: got dr=%b ir=%b addr=%h want 0 1 6100", d_ready, i_ready, bmem_addr); else passed++;
        tick(); i_read = 0;
        for (int k = 0; k < 4; k++) begin
            bmem_rvalid = 1; bmem_raddr = 32'h6000; bmem_rdata = 64'h60 + 64'(k);
            #1;
            total++; if (d_ready !== 1'b0 || i_rvalid !== 1'b1 || d_rvalid !== 1'b0)
                $display("FAIL hz_stall%0d: got dr=%b iv=%b dv=%b want 0 1 0", k, d_ready, i_rvalid, d_rvalid); else passed++;
            tick();
        end
        bmem_rvalid = 0;
        #1;
        total++; if (d_ready !== 1'b1 || bmem_addr !== 32'h6000)
            $display("FAIL hz_d_accept: got dr=%b addr=%h want 1 6000", d_ready, bmem_addr); else passed++;
        tick(); d_read = 0;
        for (int k = 0; k < 4; k++) begin
            bmem_rvalid = 1; bmem_raddr = 32'h6000; bmem_rdata = 64'h66 + 64'(k);
            #1;
            total++; if (d_rvalid !== 1'b1 || i_rvalid !== 1'b0 || d_rdata !== 64'h66 + 64'(k))
                $display("FAIL hz_dret%0d: got dv=%b iv=%b d=%h want 1 0 %h", k, d_rvalid, i_rvalid, d_rdata, 64'h66 + 64'(k)); else passed++;
            tick();
        end
        for (int k = 0; k < 4; k++) begin
            bmem_rvalid = 1; bmem_raddr = 32'h6100; bmem_rdata = 64'h61 + 64'(k);
            #1;
            total++; if (i_rvalid !== 1'b1 || d_rvalid !== 1'b0)
                $display("FAIL hz_iret%0d: got iv=%b dv=%b want 1 0", k, i_rvalid, d_rvalid); else passed++;
            tick();
        end
        bmem_rvalid = 0;
    endtask

    task automatic test_reset_mid_burst();
        d_write = 1; d_addr = 32'h8000;
        for (int k = 0; k < 2; k++) begin
            d_wdata = 64'h80 + 64'(k);
            #1;
            total++; if (d_ready !== 1'b1 || bmem_write !== 1'b1)
                $display("FAIL rst_b%0d: got dr=%b w=%b want 1 1", k, d_ready, bmem_write); else passed++;
            tick();
        end
        d_wdata = 64'h82;
        rst = 1;
        #1;
        total++; if (d_ready !== 1'b0 || bmem_write !== 1'b0 || bmem_addr !== 32'h0 || bmem_wdata !== 64'h0)
            $display("FAIL rst_mid: got dr=%b w=%b addr=%h wd=%h want all 0", d_ready, bmem_write, bmem_addr, bmem_wdata); else passed++;
        tick();
        d_write = 0; rst = 0;
        i_read = 1; i_addr = 32'h9000;
        #1;
        total++; if (i_ready !== 1'b1 || bmem_read !== 1'b1 || bmem_addr !== 32'h9000)
            $display("FAIL rst_after: got ir=%b rd=%b addr=%h want 1 1 9000", i_ready, bmem_read, bmem_addr); else passed++;
        tick(); i_read = 0;
    endtask

    initial begin
        test_reset();
        test_single_read();
        test_round_robin();
        test_write_burst();
        test_table_full();
        test_hazard();
        test_reset_mid_burst();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/bmem_arbiter.md
Name: bmem_arbiter

Overview:
- Shares the single banked burst-memory port (`bmem_*`) between the instruction-cache miss path (requester I) and the data-cache miss/writeback path (requester D) inside `cpu`.
- Grants requests round-robin and locks the port for the duration of a write burst.
- Tracks outstanding reads in a small table so that out-of-order read returns (tagged by `bmem_raddr`) reach the correct requester.

Parameters:
- `BURST_LEN`, 4, 64-bit beats per cache line (read return and write burst).
- `OUTSTANDING`, 4, maximum in-flight reads across both requesters.

Ports:
- `clk`  in  1  clock
- `rst`  in  1  asynchronous active-high reset
- `i_addr`  in  32  I line address (32-byte aligned)
- `i_read`  in  1  I read request, held until `i_ready`
- `i_ready`  out  1  I request accepted this cycle
- `i_rdata`  out  64  I return beat
- `i_rvalid`  out  1  I return beat valid
- `d_addr`  in  32  D line address
- `d_read`  in  1  D read request, held until `d_ready`
- `d_write`  in  1  D write beat present
- `d_wdata`  in  64  D write beat data
- `d_ready`  out  1  D read accepted / write beat accepted
- `d_rdata`  out  64  D return beat
- `d_rvalid`  out  1  D return beat valid
- `bmem_addr`  out  32  to memory
- `bmem_read`  out  1  to memory
- `bmem_write`  out  1  to memory
- `bmem_wdata`  out  64  to memory
- `bmem_ready`  in  1  memory can accept this cycle
- `bmem_raddr`  in  32  address tag of return beat
- `bmem_rdata`  in  64  return beat
- `bmem_rvalid`  in  1  return beat valid

Behaviour:
- Reset (async, `rst`=1):
  - All outputs 0.
  - FSM to IDLE; round-robin pointer to I; table cleared; beat counters 0.
- FSM states:
  - IDLE: arbitrate among eligible requests.
  - WBURST: D owns the port; forwards `d_write`/`d_wdata` and counts beats.
- Eligibility:
  - A read is eligible only if the table has a free entry and no valid entry holds the same address.
  - A write is always eligible in IDLE.
- Grant (IDLE):
  - Single eligible requester wins.
  - Both eligible: the requester named by the RR pointer wins; the pointer flips to the other requester on every accepted request.
  - Grant drives `bmem_*` combinationally from the winner in the same cycle.
  - The winner's `*_ready` equals `bmem_ready`.
  - Nothing is driven to memory if `bmem_ready`=0; the request stays pending and arbitration is re-evaluated next cycle.
- Read accept (read & `bmem_ready`):
  - Allocate the lowest free table entry {valid=1, addr, owner, beat_cnt=0}.
  - The requester's ready pulses for one cycle.
- Write:
  - Beat 0 accepted in IDLE moves the FSM to WBURST with beat counter = 1.
  - In WBURST, only D is forwarded; I sees `i_ready`=0.
  - `d_ready`=`bmem_ready` & `d_write`.
  - After beat `BURST_LEN`-1 is accepted, return to IDLE and flip RR to I.
  - `bmem_addr` holds the burst's beat-0 address for all beats.
- Return routing:
  - On `bmem_rvalid`, match `bmem_raddr` against valid entries (at most one match, guaranteed by eligibility).
  - Drive the owner's rdata/rvalid in the same cycle (combinational, zero latency).
  - Increment the entry's beat_cnt; on beat `BURST_LEN`-1, invalidate the entry.
  - An entry freed this cycle is not reusable until the next cycle.
- Unmatched `bmem_rvalid`: drop the beat and assert the internal sticky error flag; simulation `$error`.
- Simultaneous events:
  - A return beat and a new read accept in the same cycle are both performed.
  - Returns are routed in every state, including WBURST.
- Table full (`OUTSTANDING` valid):
  - Reads stall with ready=0.
  - D writes still proceed.
- Read hazards:
  - A requester whose read matches an outstanding address stalls until that entry frees.
  - The other requester is not blocked.
- Reset mid-burst or mid-return: the state machine and table are cleared immediately; later return beats are treated as unmatched.

Test Plan:
- Single I read to 0x1000, `bmem_ready`=1 → `i_ready` pulses in cycle 0. Four returns tagged 0x1000 → four `i_rvalid` pulses with the same data; `d_rvalid` stays 0; entry freed.
- I and D read 0x2000/0x3000 in the same cycle, RR=I → I granted cycle 0, D granted cycle 1. Returns interleaved D,I,D,... → each beat goes to the correct owner.
- D write burst at 0x4000, beats A,B,C,D, with `i_read` held → `bmem_write` high for 4 accepted beats with `bmem_addr`=0x4000. I is granted only after beat 3, in the following cycle.
- Four reads outstanding, fifth read at 0x5000 → `*_ready`=0 until the first entry completes its 4th beat. Accepted one cycle later.
- D read 0x6000 while I 0x6000 is in flight → D stalls until I's last beat. D return beats are not delivered to I.
- Assert `rst` during WBURST beat 2 → outputs 0 immediately; after release the FSM is IDLE and an I read is granted on the first cycle.
